// File: rtl/fpu_mantissa_divider_if.sv
// Handshake/result bundle for the iterative mantissa divider.
// Define FPU_DIV_STICKY_EN to add the sticky output used by the rounding stage.
interface fpu_mantissa_divider_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [WIDTH-1:0] divIn1;
    logic [WIDTH-1:0] divIn2;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             divByZero;
`ifdef FPU_DIV_STICKY_EN
    logic             sticky;

    modport master (
        output start, divIn1, divIn2,
        input  quotient, remainder, busy, done, divByZero, sticky
    );
    modport slave (
        input  start, divIn1, divIn2,
        output quotient, remainder, busy, done, divByZero, sticky
    );
`else
    modport master (
        output start, divIn1, divIn2,
        input  quotient, remainder, busy, done, divByZero
    );
    modport slave (
        input  start, divIn1, divIn2,
        output quotient, remainder, busy, done, divByZero
    );
`endif
endinterface

// File: rtl/fpu_mantissa_divider.sv
// Radix-2 restoring mantissa divider, one quotient bit per cycle.
// Optional FPU_DIV_STICKY_EN adds a registered sticky (remainder != 0) output.
module fpu_mantissa_divider #(
    parameter int WIDTH = 24
) (
    input  logic                         clock,
    input  logic                         reset,
    fpu_mantissa_divider_if.slave        bus
);
    localparam int CNTWIDTH = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_DZ   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    div_q, div_d;
    logic [WIDTH-1:0]    rem_sh_q, rem_sh_d;
    logic [WIDTH-1:0]    quo_sh_q, quo_sh_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    quotient_q, quotient_d;
    logic [WIDTH-1:0]    remainder_q, remainder_d;
    logic                dbz_q, dbz_d;
`ifdef FPU_DIV_STICKY_EN
    logic                sticky_q, sticky_d;
`endif

    // Partial remainder after the shift needs one extra bit: it can reach 2*D-1.
    logic [WIDTH:0]      shifted;
    logic                fits;
    logic [WIDTH-1:0]    rem_step;
    logic [WIDTH-1:0]    quo_step;

    always_comb begin
        shifted  = {rem_sh_q, quo_sh_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, div_q});
        rem_step = fits ? WIDTH'(shifted - {1'b0, div_q}) : shifted[WIDTH-1:0];
        quo_step = {quo_sh_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        rem_sh_d    = rem_sh_q;
        quo_sh_d    = quo_sh_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef FPU_DIV_STICKY_EN
        sticky_d    = sticky_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    div_d    = bus.divIn2;
                    rem_sh_d = '0;
                    quo_sh_d = bus.divIn1;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    state_d  = (bus.divIn2 == '0) ? S_DZ : S_COMP;
                end
            end
            S_COMP: begin
                rem_sh_d = rem_step;
                quo_sh_d = quo_step;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNTWIDTH'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_step;
                    remainder_d = rem_step;
`ifdef FPU_DIV_STICKY_EN
                    sticky_d    = (rem_step != '0);
`endif
                end
            end
            default: begin
                // Divide by zero: saturate quotient, pass the dividend through as remainder.
                state_d     = S_DONE;
                quotient_d  = '1;
                remainder_d = quo_sh_q;
                dbz_d       = 1'b1;
`ifdef FPU_DIV_STICKY_EN
                sticky_d    = (quo_sh_q != '0);
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            rem_sh_q    <= '0;
            quo_sh_q    <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef FPU_DIV_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rem_sh_q    <= rem_sh_d;
            quo_sh_q    <= quo_sh_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef FPU_DIV_STICKY_EN
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = (state_q == S_COMP);
    assign bus.done      = (state_q == S_DONE);
    assign bus.divByZero = dbz_q & (state_q == S_DONE);
`ifdef FPU_DIV_STICKY_EN
    assign bus.sticky    = sticky_q;
`endif

endmodule
